// File: rtl/tile_gfx_pkg.sv
// Shared constants, FSM state type and colour reduction
// for the tile-drawer pixel pipeline.
package tile_gfx_pkg;

    localparam int SCREEN_W_DEF   = 160;
    localparam int SCREEN_H_DEF   = 120;
    localparam int COLOR_BITS_DEF = 3;

    // Pixel-word field widths (colour width follows COLOR_BITS)
    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // Keep the top cb bits of each 8-bit channel; result is
    // right-aligned {R,G,B} in the low 3*cb bits.
    function automatic logic [23:0] reduce_rgb(
        input logic [23:0] rgb,
        input int          cb
    );
        logic [23:0] r8;
        logic [23:0] g8;
        logic [23:0] b8;
        r8 = {16'b0, rgb[23:16] >> (8 - cb)};
        g8 = {16'b0, rgb[15:8] >> (8 - cb)};
        b8 = {16'b0, rgb[7:0] >> (8 - cb)};
        return (r8 << (2 * cb)) | (g8 << cb) | b8;
    endfunction

endpackage

// File: rtl/pixel_bus_receiver_if.sv
// Frame-buffer write port: valid/ready handshake carrying
// one reduced-colour pixel per transfer.
interface pixel_bus_receiver_if #(
    parameter int CB = 3
);
    logic            fb_we;
    logic [7:0]      fb_x;
    logic [6:0]      fb_y;
    logic [3*CB-1:0] fb_colour;
    logic            fb_ready;

    modport master (
        output fb_we,
        output fb_x,
        output fb_y,
        output fb_colour,
        input  fb_ready
    );

    modport slave (
        input  fb_we,
        input  fb_x,
        input  fb_y,
        input  fb_colour,
        output fb_ready
    );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for captured pixel words. Push while
// full is accepted only together with a pop; no bypass when empty.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_bus_receiver.sv
// Tile-drawer pixel bus sink: clip, colour reduce and queue pixels,
// then write them to the frame buffer; sweeps a full-screen clear.
module pixel_bus_receiver
    import tile_gfx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_draw_enable_bus,
    input  logic [7:0]           vga_x_out_bus,
    input  logic [7:0]           vga_y_out_bus,
    input  logic [23:0]          vga_RGB_out_bus,
    input  logic                 clear_req,
    input  logic [23:0]          clear_colour,
    pixel_bus_receiver_if.master fb,
    output logic                 busy,
    output logic                 overflow,
    output logic [7:0]           clip_count
);
    localparam int CW    = 3 * COLOR_BITS;
    localparam int PW    = X_W + Y_W + CW;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [7:0] W_LIM  = 8'(SCREEN_W);
    localparam logic [7:0] H_LIM  = 8'(SCREEN_H);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_t state_q;
    state_t state_d;

    logic strobe;
    logic clipped;
    logic keep;
    logic push;
    logic pop;
    logic clr_start;
    logic sweep_end;
    logic xfer;
    logic load_ok;
    logic at_last;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [PW-1:0]    fifo_head;
    logic [PW-1:0]    px_word;

    logic [23:0]   px_red;
    logic [23:0]   clr_red;
    logic          unused_red;
    logic [CW-1:0] clr_col_q;
    logic [CW-1:0] clr_col_next;
    logic          clear_pending;

    logic          out_valid;
    logic [7:0]    out_x;
    logic [6:0]    out_y;
    logic [CW-1:0] out_col;

    // Capture and clip: anything other than a solid 1 is idle
    assign strobe  = (vga_draw_enable_bus == 1'b1);
    assign clipped = strobe &&
                     ((vga_x_out_bus >= W_LIM) ||
                      (vga_y_out_bus >= H_LIM));
    assign keep    = strobe && !clipped;
    assign push    = keep && (!fifo_full || pop);

    assign px_red  = reduce_rgb(vga_RGB_out_bus, COLOR_BITS);
    assign clr_red = reduce_rgb(clear_colour, COLOR_BITS);
    assign unused_red = ^{px_red[23:CW], clr_red[23:CW]};

    assign px_word = {vga_x_out_bus,
                      vga_y_out_bus[6:0],
                      px_red[CW-1:0]};

    // A request arriving with the sweep start uses its own colour
    assign clr_col_next = clear_req ? clr_red[CW-1:0] : clr_col_q;

    assign xfer    = out_valid && fb.fb_ready;
    assign load_ok = !out_valid || xfer;
    assign at_last = (out_x == X_LAST) && (out_y == Y_LAST);

    assign fb.fb_we     = out_valid;
    assign fb.fb_x      = out_x;
    assign fb.fb_y      = out_y;
    assign fb.fb_colour = out_col;

    assign busy = (state_q != S_IDLE) ||
                  (fifo_count != '0) ||
                  out_valid ||
                  clear_pending;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (px_word),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus pop / sweep-start / sweep-end strobes
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        clr_start = 1'b0;
        sweep_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clear_req || clear_pending) begin
                    clr_start = load_ok;
                    state_d   = S_CLEAR;
                end else if (!fifo_empty) begin
                    pop     = load_ok;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    pop = load_ok;
                end else if (load_ok) begin
                    if (clear_pending || clear_req) begin
                        clr_start = 1'b1;
                        state_d   = S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                if (xfer && at_last) begin
                    sweep_end = 1'b1;
                    state_d   = fifo_empty ? S_IDLE : S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: FIFO head, sweep start, or sweep advance
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_col   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            {out_x, out_y, out_col} <= fifo_head;
        end else if (clr_start) begin
            out_valid <= 1'b1;
            out_x     <= '0;
            out_y     <= '0;
            out_col   <= clr_col_next;
        end else if ((state_q == S_CLEAR) && xfer) begin
            if (sweep_end) begin
                out_valid <= 1'b0;
            end else if (out_x == X_LAST) begin
                out_x <= '0;
                out_y <= out_y + 1'b1;
            end else begin
                out_x <= out_x + 1'b1;
            end
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Clear request bookkeeping; requests during a sweep are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_pending <= 1'b0;
            clr_col_q     <= '0;
        end else begin
            if (clear_req && (state_q != S_CLEAR)) begin
                clear_pending <= 1'b1;
                clr_col_q     <= clr_red[CW-1:0];
            end
            if (sweep_end) begin
                clear_pending <= 1'b0;
            end
        end
    end

    // Sticky overflow and saturating clip counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (keep && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (clipped && (clip_count != 8'hFF)) begin
                clip_count <= clip_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_bus_receiver.sv
// Self-checking bench for pixel_bus_receiver: table vectors,
// random traffic against a queue model, and clear/reset corner cases.
module tb_pixel_bus_receiver;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
    } wr_t;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
        bit          clip;
        logic [8:0]  col;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  vx = '0;
    logic [7:0]  vy = '0;
    logic [23:0] rgb = '0;
    logic        clear_req = 1'b0;
    logic [23:0] clear_colour = '0;
    logic        busy;
    logic        overflow;
    logic [7:0]  clip_count;

    int checks;
    int failures;
    int cyc = 0;

    wr_t  got_q[$];
    int   got_cyc[$];
    wr_t  exp_q[$];
    vec_t tbl[10];

    int n;
    int nb;
    int bad;
    int exp_clip;
    int nclip;
    int rx;
    int ry;
    logic [23:0] rrgb;

    pixel_bus_receiver_if #(.CB(3)) fbi ();

    pixel_bus_receiver #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .COLOR_BITS (3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .vga_draw_enable_bus (en),
        .vga_x_out_bus       (vx),
        .vga_y_out_bus       (vy),
        .vga_RGB_out_bus     (rgb),
        .clear_req           (clear_req),
        .clear_colour        (clear_colour),
        .fb                  (fbi),
        .busy                (busy),
        .overflow            (overflow),
        .clip_count          (clip_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write that the coming edge will accept
    always @(negedge clk) begin
        if (!reset && fbi.fb_we && fbi.fb_ready) begin
            got_q.push_back(wr_t'{x: fbi.fb_x, y: fbi.fb_y, c: fbi.fb_colour});
            got_cyc.push_back(cyc);
        end
    end

    function automatic wr_t mk(input logic [7:0] x, input logic [6:0] y,
                               input logic [8:0] c);
        return wr_t'{x: x, y: y, c: c};
    endfunction

    // Reference: colour keeps the top 3 bits of each channel
    function automatic wr_t ref_px(input int x, input int y, input logic [23:0] c);
        int r;
        int g;
        int b;
        r = ((int'(c) >> 16) & 255) / 32;
        g = ((int'(c) >> 8) & 255) / 32;
        b = (int'(c) & 255) / 32;
        return mk(8'(x), 7'(y), 9'(r * 64 + g * 8 + b));
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] x, input logic [7:0] y,
                          input logic [23:0] c);
        en  = 1'b1;
        vx  = x;
        vy  = y;
        rgb = c;
        tick();
        en  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((busy || fbi.fb_we) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(k < budget), 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fbi.fb_ready = 1'b1;

        tbl[0] = '{x: 8'd5,   y: 8'd7,   rgb: 24'hFF8040, clip: 1'b0, col: 9'b111_100_010};
        tbl[1] = '{x: 8'd160, y: 8'd3,   rgb: 24'hFFFFFF, clip: 1'b1, col: 9'h0};
        tbl[2] = '{x: 8'd10,  y: 8'd120, rgb: 24'hFFFFFF, clip: 1'b1, col: 9'h0};
        tbl[3] = '{x: 8'd159, y: 8'd119, rgb: 24'h123456, clip: 1'b0, col: 9'b000_001_010};
        tbl[4] = '{x: 8'd0,   y: 8'd0,   rgb: 24'h000000, clip: 1'b0, col: 9'b000_000_000};
        tbl[5] = '{x: 8'd255, y: 8'd0,   rgb: 24'hABCDEF, clip: 1'b1, col: 9'h0};
        tbl[6] = '{x: 8'd0,   y: 8'd255, rgb: 24'hABCDEF, clip: 1'b1, col: 9'h0};
        tbl[7] = '{x: 8'd159, y: 8'd0,   rgb: 24'hE0E0E0, clip: 1'b0, col: 9'b111_111_111};
        tbl[8] = '{x: 8'd100, y: 8'd127, rgb: 24'h808080, clip: 1'b1, col: 9'h0};
        tbl[9] = '{x: 8'd0,   y: 8'd119, rgb: 24'h1F2F3F, clip: 1'b0, col: 9'b000_001_001};

        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(fbi.fb_we), 0);
        chk("rst_x", 32'(fbi.fb_x), 0);
        chk("rst_y", 32'(fbi.fb_y), 0);
        chk("rst_col", 32'(fbi.fb_colour), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_clip", 32'(clip_count), 0);
        reset = 1'b0;
        tick();

        // Single pixel latency
        got_q.delete();
        strobe(8'd5, 8'd7, 24'hFF8040);
        @(negedge clk);
        chk("lat_n_we", 32'(fbi.fb_we), 0);
        chk("lat_n_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_n1_we", 32'(fbi.fb_we), 1);
        chk("lat_n1_x", 32'(fbi.fb_x), 5);
        chk("lat_n1_y", 32'(fbi.fb_y), 7);
        chk("lat_n1_col", 32'(fbi.fb_colour), 32'(9'b111_100_010));
        @(negedge clk);
        chk("lat_n2_we", 32'(fbi.fb_we), 0);
        chk("lat_n2_busy", 32'(busy), 0);
        chk("lat_nwr", 32'(got_q.size()), 1);
        tick();

        // Table vectors
        exp_clip = 0;
        for (int i = 0; i < 10; i++) begin
            got_q.delete();
            strobe(tbl[i].x, tbl[i].y, tbl[i].rgb);
            repeat (4) tick();
            if (tbl[i].clip) exp_clip++;
            chk("tbl_clipcnt", 32'(clip_count), 32'(exp_clip));
            if (tbl[i].clip) begin
                chk("tbl_nowr", 32'(got_q.size()), 0);
            end else begin
                chk("tbl_nwr", 32'(got_q.size()), 1);
                if (got_q.size() > 0)
                    chk("tbl_px", 32'(got_q[0]),
                        32'(mk(tbl[i].x, tbl[i].y[6:0], tbl[i].col)));
            end
        end

        // Clip counter saturation
        got_q.delete();
        for (int i = 0; i < 300; i++) strobe(8'd200, 8'(i), 24'h0);
        tick();
        chk("clip_sat", 32'(clip_count), 255);
        chk("clip_nowr", 32'(got_q.size()), 0);

        // Overflow with stalled frame buffer
        do_reset();
        got_q.delete();
        got_cyc.delete();
        fbi.fb_ready = 1'b0;
        for (int i = 1; i <= 6; i++)
            strobe(8'(i * 10), 8'(i), 24'(i * 24'h010101 * 32));
        repeat (3) tick();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_we", 32'(fbi.fb_we), 1);
        chk("ovf_hold_x", 32'(fbi.fb_x), 10);
        chk("ovf_nowr", 32'(got_q.size()), 0);
        fbi.fb_ready = 1'b1;
        wait_idle(20, "ovf_timeout");
        chk("ovf_nwr", 32'(got_q.size()), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            chk("ovf_order_x", 32'(got_q[i].x), 32'((i + 1) * 10));
            chk("ovf_order_y", 32'(got_q[i].y), 32'(i + 1));
            if (i > 0)
                chk("ovf_rate", 32'(got_cyc[i] - got_cyc[i - 1]), 1);
        end
        chk("ovf_sticky", 32'(overflow), 1);

        // Random traffic against the queue model
        do_reset();
        got_q.delete();
        exp_q.delete();
        nclip = 0;
        for (int i = 0; i < 800; i++) begin
            fbi.fb_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 1) == 1) begin
                rx   = int'($urandom_range(0, 190));
                ry   = int'($urandom_range(0, 140));
                rrgb = 24'($urandom);
                if (rx >= 160 || ry >= 120) begin
                    nclip++;
                    strobe(8'(rx), 8'(ry), rrgb);
                end else if (exp_q.size() - got_q.size() < 4) begin
                    exp_q.push_back(ref_px(rx, ry, rrgb));
                    strobe(8'(rx), 8'(ry), rrgb);
                end else begin
                    tick();
                end
            end else begin
                tick();
            end
        end
        fbi.fb_ready = 1'b1;
        wait_idle(100, "rand_timeout");
        chk("rand_nwr", 32'(got_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk("rand_stream", 32'(bad), 0);
        chk("rand_ovf", 32'(overflow), 0);
        chk("rand_clip", 32'(clip_count), 32'(nclip > 255 ? 255 : nclip));

        // Full clear sweep, black
        do_reset();
        got_q.delete();
        got_cyc.delete();
        clear_colour = 24'h000000;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_colour = 24'hFFFFFF;
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        chk("clr_timeout", 32'(n < 20000), 1);
        chk("clr_nwr", 32'(got_q.size()), 19200);
        if (got_q.size() == 19200) begin
            bad = 0;
            for (int i = 0; i < 19200; i++)
                if (got_q[i] !== mk(8'(i % 160), 7'(i / 160), 9'h0)) bad++;
            chk("clr_order", 32'(bad), 0);
            chk("clr_first", 32'(got_q[0]), 32'(mk(8'd0, 7'd0, 9'h0)));
            chk("clr_last", 32'(got_q[19199]), 32'(mk(8'd159, 7'd119, 9'h0)));
            chk("clr_busy_lag", 32'(cyc - got_cyc[19199]), 1);
        end

        // Pixel strobed mid-clear waits for the sweep; re-request ignored
        got_q.delete();
        clear_colour = 24'hFFFFFF;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_colour = 24'h000000;
        repeat (100) tick();
        strobe(8'd33, 8'd44, 24'h20A0C0);
        repeat (100) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        chk("mid_timeout", 32'(n < 20000), 1);
        chk("mid_nwr", 32'(got_q.size()), 19201);
        if (got_q.size() == 19201) begin
            bad = 0;
            for (int i = 0; i < 19200; i++)
                if (got_q[i] !== mk(8'(i % 160), 7'(i / 160), 9'h1FF)) bad++;
            chk("mid_sweep", 32'(bad), 0);
            chk("mid_last", 32'(got_q[19199]), 32'(mk(8'd159, 7'd119, 9'h1FF)));
            chk("mid_px", 32'(got_q[19200]), 32'(ref_px(33, 44, 24'h20A0C0)));
        end

        // Clear requested while draining three pixels
        got_q.delete();
        got_cyc.delete();
        strobe(8'd1, 8'd2, 24'hFF0000);
        strobe(8'd3, 8'd4, 24'h00FF00);
        strobe(8'd5, 8'd6, 24'h0000FF);
        clear_colour = 24'h402000;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_colour = 24'hFFFFFF;
        n = 0;
        while (got_q.size() < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("drc_timeout", 32'(n < 200), 1);
        if (got_q.size() >= 8) begin
            chk("drc_p0", 32'(got_q[0]), 32'(ref_px(1, 2, 24'hFF0000)));
            chk("drc_p1", 32'(got_q[1]), 32'(ref_px(3, 4, 24'h00FF00)));
            chk("drc_p2", 32'(got_q[2]), 32'(ref_px(5, 6, 24'h0000FF)));
            chk("drc_s0", 32'(got_q[3]), 32'(ref_px(0, 0, 24'h402000)));
            chk("drc_s1", 32'(got_q[4]), 32'(ref_px(1, 0, 24'h402000)));
            chk("drc_after", 32'(got_cyc[3] > got_cyc[2]), 1);
        end

        // Reset in the middle of the sweep
        chk("rmc_pre_we", 32'(fbi.fb_we), 1);
        nb = got_q.size();
        reset = 1'b1;
        tick();
        chk("rmc_we", 32'(fbi.fb_we), 0);
        chk("rmc_x", 32'(fbi.fb_x), 0);
        chk("rmc_y", 32'(fbi.fb_y), 0);
        chk("rmc_col", 32'(fbi.fb_colour), 0);
        chk("rmc_busy", 32'(busy), 0);
        chk("rmc_ovf", 32'(overflow), 0);
        chk("rmc_clip", 32'(clip_count), 0);
        reset = 1'b0;
        repeat (50) tick();
        chk("rmc_nowr", 32'(got_q.size()), 32'(nb));
        chk("rmc_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
